// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared types and sizing helpers for the chunked adder
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int nch(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A single-chunk operation still needs a 1-bit index register.
  function automatic int idx_width(input int n_chunks);
    return (n_chunks > 1) ? clog2(n_chunks) : 1;
  endfunction

endpackage

// File: rtl/half_adder.sv
// rtl/half_adder.sv - one-bit half adder
module half_adder (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;

endmodule

// File: rtl/ripple_chunk_adder.sv
// rtl/ripple_chunk_adder.sv - CHUNK-bit ripple adder built from half-adder pairs
module ripple_chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0]   w_c;
  logic [CHUNK-1:0] w_p;
  logic [CHUNK-1:0] w_g;
  logic [CHUNK-1:0] w_t;

  assign w_c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    half_adder u_ha_ab (
      .i_a (a[i]),
      .i_b (b[i]),
      .o_s (w_p[i]),
      .o_c (w_g[i])
    );
    half_adder u_ha_c (
      .i_a (w_p[i]),
      .i_b (w_c[i]),
      .o_s (s[i]),
      .o_c (w_t[i])
    );
    assign w_c[i+1] = w_g[i] | w_t[i];
  end

  assign cout  = w_c[CHUNK];
  assign c_msb = w_c[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// rtl/seq_chunk_adder.sv - multi-cycle add/subtract, CHUNK bits per clock
module seq_chunk_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int NCH  = nch(WIDTH, CHUNK);
  localparam int IDXW = idx_width(NCH);
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCH - 1);

  if ((WIDTH % CHUNK) != 0 || WIDTH < 2 || CHUNK < 1) begin : g_bad_params
    $fatal(1, "seq_chunk_adder: CHUNK must divide WIDTH and WIDTH must be >= 2");
  end

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_accept;
  logic              w_last;

  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_part;
  logic              r_carry;
  logic              r_sub;
  logic [IDXW-1:0]   r_idx;
  logic [WIDTH-1:0]  r_sum;
  logic              r_cout;
  logic              r_ovf;

  int                w_base;
  logic [CHUNK-1:0]  w_a_chunk;
  logic [CHUNK-1:0]  w_b_chunk;
  logic [CHUNK-1:0]  w_s;
  logic              w_cout;
  logic              w_c_msb;
  logic [WIDTH-1:0]  w_part_nxt;

  assign w_last = (r_idx == IDX_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: if (start) begin
        w_state_nxt = RUN;
        w_accept    = 1'b1;
      end
      RUN: if (w_last) w_state_nxt = DONE;
      DONE: begin
        w_state_nxt = start ? RUN : IDLE;
        w_accept    = start;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Partial result with the current chunk merged in; at the last chunk this is the full Sum.
  always_comb begin
    w_base     = int'(r_idx) * CHUNK;
    w_a_chunk  = r_a[w_base +: CHUNK];
    w_b_chunk  = r_b[w_base +: CHUNK];
    w_part_nxt = r_part;
    w_part_nxt[w_base +: CHUNK] = w_s;
  end

  ripple_chunk_adder #(.CHUNK(CHUNK)) u_ripple (
    .a     (w_a_chunk),
    .b     (w_b_chunk),
    .cin   (r_carry),
    .s     (w_s),
    .cout  (w_cout),
    .c_msb (w_c_msb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_part  <= '0;
      r_carry <= 1'b0;
      r_sub   <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      // Subtraction runs as A + ~B + ~Cin through the same adder.
      r_a     <= A;
      r_b     <= sub ? ~B : B;
      r_carry <= Cin ^ sub;
      r_sub   <= sub;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_part  <= w_part_nxt;
      r_carry <= w_cout;
      r_idx   <= w_last ? '0 : r_idx + IDX_ONE;
      if (w_last) begin
        r_sum  <= w_part_nxt;
        r_cout <= w_cout ^ r_sub;
        r_ovf  <= w_c_msb ^ w_cout;
      end
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign Sum  = r_sum;
  assign Cout = r_cout;
  assign Ovf  = r_ovf;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb/tb_seq_chunk_adder.sv - randomized model-checked bench over three width/chunk configurations
module tb_seq_chunk_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Result packed as {ovf, cout, sum[31:0]} using plain signed/unsigned arithmetic.
  function automatic logic [33:0] ref_op(input int w, input logic [31:0] a, input logic [31:0] b,
                                         input logic cin, input logic sub);
    longint mask, ua, ub, sa, sb, full, r, hi, lo, ci;
    logic cout, ovf;
    logic [31:0] sum;
    mask = (64'sd1 <<< w) - 1;
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    ci   = longint'(cin);
    sa   = (((ua >>> (w - 1)) & 1) != 0) ? ua - (mask + 1) : ua;
    sb   = (((ub >>> (w - 1)) & 1) != 0) ? ub - (mask + 1) : ub;
    if (!sub) begin
      full = ua + ub + ci;
      cout = ((full >>> w) & 1) != 0;
      r    = sa + sb + ci;
    end else begin
      full = ua - ub - ci;
      cout = ua < (ub + ci);
      r    = sa - sb - ci;
    end
    hi  = mask >>> 1;
    lo  = -hi - 1;
    ovf = (r > hi) || (r < lo);
    sum = 32'(full & mask);
    return {ovf, cout, sum};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int W   = (g == 0) ? 16 : ((g == 1) ? 8 : 32);
    localparam int C   = (g == 0) ? 4  : ((g == 1) ? 8 : 2);
    localparam int NCH = W / C;

    logic         rst = 1'b1, start = 1'b0, sub = 1'b0, cin = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic [W-1:0] sum;
    logic         busy, done, cout, ovf;
    bit           fin = 1'b0;
    int           lat;

    seq_chunk_adder #(.WIDTH(W), .CHUNK(C)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .sub   (sub),
      .A     (a),
      .B     (b),
      .Cin   (cin),
      .busy  (busy),
      .done  (done),
      .Sum   (sum),
      .Cout  (cout),
      .Ovf   (ovf)
    );

    // Model: an accepted start finishes exactly NCH edges later; results only move then.
    int           m_rem  = 0;
    logic         m_done = 1'b0, m_cout = 1'b0, m_ovf = 1'b0;
    logic [W-1:0] m_sum  = '0;
    logic [33:0]  m_pend = '0;
    logic [33:0]  w_ref;
    assign w_ref = ref_op(W, 32'(a), 32'(b), cin, sub);

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        m_rem <= 0; m_done <= 1'b0; m_sum <= '0; m_cout <= 1'b0; m_ovf <= 1'b0;
      end else if (m_rem != 0) begin
        m_rem  <= m_rem - 1;
        m_done <= (m_rem == 1);
        if (m_rem == 1) begin
          m_sum  <= m_pend[W-1:0];
          m_cout <= m_pend[32];
          m_ovf  <= m_pend[33];
        end
      end else begin
        m_done <= 1'b0;
        if (start) begin
          m_rem  <= NCH;
          m_pend <= w_ref;
        end
      end
    end

    always @(negedge clk) begin
      n_cmp++;
      if ({busy, done, sum, cout, ovf} !== {m_rem != 0, m_done, m_sum, m_cout, m_ovf}) begin
        n_fail++;
        $display("FAIL cycle W=%0d t=%0t busy/done/sum/cout/ovf got %b/%b/%h/%b/%b expected %b/%b/%h/%b/%b",
                 W, $time, busy, done, sum, cout, ovf, m_rem != 0, m_done, m_sum, m_cout, m_ovf);
      end
    end

    task automatic step();
      @(posedge clk);
      #2;
    endtask

    function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
        0:       return '0;
        1:       return '1;
        2:       return {1'b1, {(W-1){1'b0}}};
        3:       return {1'b0, {(W-1){1'b1}}};
        default: return W'({$urandom(), $urandom()});
      endcase
    endfunction

    task automatic run_op(input logic [31:0] va, input logic [31:0] vb, input logic vc,
                          input logic vs, input bit inject);
      start = 1'b1; a = W'(va); b = W'(vb); cin = vc; sub = vs;
      step();
      start = 1'b0;
      lat   = 0;
      while (!done && lat < NCH + 4) begin
        if (inject && lat == 0) begin
          start = 1'b1; a = ~a; b = ~b; cin = ~cin; sub = ~sub;
        end else begin
          start = 1'b0;
        end
        step();
        lat++;
      end
      start = 1'b0;
      chk($sformatf("latency_w%0d", W), 64'(lat), 64'(NCH));
    endtask

    initial begin
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      repeat (3) step();
      chk($sformatf("reset_idle_w%0d", W), 64'({busy, done, sum, cout, ovf}), 64'd0);

      run_op(32'h1234, 32'h0001, 1'b0, 1'b0, 1'b1);
      step(); step();
      run_op(32'hFFFF, 32'h0001, 1'b0, 1'b0, 1'b0);
      run_op(32'h7FFF, 32'h0001, 1'b0, 1'b0, 1'b0);
      run_op(32'h0005, 32'h0007, 1'b0, 1'b1, 1'b0);
      run_op(32'h8000, 32'h0001, 1'b0, 1'b1, 1'b0);
      step(); step();

      start = 1'b1; a = W'(32'hABCD1234); b = W'(32'h13579BDF); cin = 1'b1; sub = 1'b0;
      step();
      start = 1'b0;
      step();
      rst = 1'b1;
      #1;
      chk($sformatf("async_reset_w%0d", W), 64'({busy, done, sum, cout, ovf}), 64'd0);
      step();
      rst = 1'b0;
      step();

      repeat (1000 * (NCH + 2)) begin
        step();
        rst   = ($urandom_range(0, 999) == 0);
        start = ($urandom_range(0, 2) == 0);
        a     = pick();
        b     = pick();
        cin   = 1'($urandom_range(0, 1));
        sub   = 1'($urandom_range(0, 1));
      end
      rst = 1'b0; start = 1'b0;
      repeat (NCH + 3) step();
      fin = 1'b1;
    end
  end

  initial begin
    chk("pin_add",      64'(ref_op(16, 32'h1234, 32'h0001, 1'b0, 1'b0)), 64'({2'b00, 32'h0000_1235}));
    chk("pin_carry",    64'(ref_op(16, 32'hFFFF, 32'h0001, 1'b0, 1'b0)), 64'({2'b01, 32'h0000_0000}));
    chk("pin_ovf_add",  64'(ref_op(16, 32'h7FFF, 32'h0001, 1'b0, 1'b0)), 64'({2'b10, 32'h0000_8000}));
    chk("pin_borrow",   64'(ref_op(16, 32'h0005, 32'h0007, 1'b0, 1'b1)), 64'({2'b01, 32'h0000_FFFE}));
    chk("pin_ovf_sub",  64'(ref_op(16, 32'h8000, 32'h0001, 1'b0, 1'b1)), 64'({2'b10, 32'h0000_7FFF}));
    chk("pin_w8_cin",   64'(ref_op(8,  32'h80,   32'h80,   1'b1, 1'b0)), 64'({2'b11, 32'h0000_0001}));
    chk("pin_w32_bin",  64'(ref_op(32, 32'h0,    32'h0,    1'b1, 1'b1)), 64'({2'b01, 32'hFFFF_FFFF}));

    for (int i = 0; i < 90000; i++) begin
      if (g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin) break;
      @(posedge clk);
    end
    if (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin)) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout: stimulus finished %b%b%b required 111",
               g_cfg[2].fin, g_cfg[1].fin, g_cfg[0].fin);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
